arith_unit_seq: RTL

Parametrised, clocked successor to the 4-bit enable/select add-subtract unit. Accepts one operation per handshake: ADD, SUB, ACCUMULATE, or MULTIPLY, on WIDTH-bit unsigned operands. Produces a registered result with carry/zero flags behind a valid/ready output. It sits between the switch/operand front end and the LED/display stage, and replaces the combinational unit wherever multi-cycle ops or backpressure are needed.

---
 rtl/arith_pkg.sv | 19 +
 rtl/arith_mul_seq.sv | 77 +++++++
 rtl/arith_unit_seq.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared encodings for the sequential arithmetic unit: operation codes and control states.
// Latency: none, this file holds type definitions only.
// Backpressure: none, this file holds type definitions only.
package arith_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_ACC = 2'd2,
    OP_MUL = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/arith_mul_seq.sv
// Shift-add unsigned multiplier that consumes one multiplier bit per cycle.
// Latency: start consumes bit 0, and done pulses WIDTH cycles after start with the final product.
// Backpressure: none; the caller issues start only when it can take the done pulse.
module arith_mul_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  logic              run_q, run_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [RW-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [RW-1:0]     prod_q, prod_d;
  logic              done_q, done_d;

  // Next-state for the datapath.
  // The start cycle already folds in b[0], so WIDTH-1 further steps remain.
  always_comb begin
    run_d    = run_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    done_d   = 1'b0;
    if (start) begin
      mcand_d  = {{WIDTH{1'b0}}, a} << 1;
      mplier_d = b >> 1;
      prod_d   = b[0] ? {{WIDTH{1'b0}}, a} : '0;
      cnt_d    = CW'(WIDTH - 1);
      run_d    = 1'b1;
    end else if (run_q) begin
      if (mplier_q[0]) begin
        prod_d = prod_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        done_d = 1'b1;
        run_d  = 1'b0;
      end
    end
  end

  // Datapath registers. Reset abandons any multiply in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      run_q    <= run_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      done_q   <= done_d;
    end
  end

  assign done    = done_q;
  assign product = prod_q;

endmodule

// File: rtl/arith_unit_seq.sv
// Registered ADD/SUB/ACC/MUL unit with valid/ready on both sides. ARITH_SAT_EN selects saturating ADD, SUB and ACC.
// Latency: ADD, SUB and ACC take 1 cycle, and MUL takes WIDTH+1 cycles with no new accept until the cycle after its result.
// Backpressure: the output register holds while out_valid & ~out_ready, and in_ready drops until out_ready frees it.
module arith_unit_seq
  import arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   input_a,
  input  logic [WIDTH-1:0]   input_b,
  input  logic               acc_clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               carry,
  output logic               zero
);

  localparam int RW = 2 * WIDTH;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic              out_valid_q, out_valid_d;
  logic [RW-1:0]     result_q, result_d;
  logic              carry_q, carry_d;
  logic              zero_q, zero_d;

  op_t               op_e;
  logic              accept;
  logic              mul_start;
  logic              mul_done;
  logic [RW-1:0]     mul_product;

  logic [WIDTH:0]    sum;
  logic [WIDTH:0]    acc_sum;
  logic [WIDTH-1:0]  acc_base;
  logic [WIDTH-1:0]  acc_new;
  logic [WIDTH-1:0]  alu_lo;
  logic              alu_hi;
  logic              alu_carry;

  assign op_e      = op_t'(op);
  assign in_ready  = ~rst & enable & (state_q == IDLE) & (~out_valid_q | out_ready);
  assign accept    = in_valid & in_ready;
  assign mul_start = accept & (op_e == OP_MUL);

  arith_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (input_a),
    .b       (input_b),
    .done    (mul_done),
    .product (mul_product)
  );

  // Single-cycle ALU. A clear coinciding with ACC starts the sum from zero.
  always_comb begin
    sum       = {1'b0, input_a} + {1'b0, input_b};
    acc_base  = acc_clr ? '0 : acc_q;
    acc_sum   = {1'b0, acc_base} + {1'b0, input_a};
    acc_new   = acc_sum[WIDTH-1:0];
    alu_lo    = '0;
    alu_hi    = 1'b0;
    alu_carry = 1'b0;
`ifdef ARITH_SAT_EN
    if (acc_sum[WIDTH]) begin
      acc_new = '1;
    end
`endif
    case (op_e)
      OP_ADD: begin
        alu_carry = sum[WIDTH];
`ifdef ARITH_SAT_EN
        alu_lo = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
        alu_lo = sum[WIDTH-1:0];
        alu_hi = sum[WIDTH];
`endif
      end
      OP_SUB: begin
        alu_carry = (input_a < input_b);
`ifdef ARITH_SAT_EN
        alu_lo = (input_a < input_b) ? '0 : (input_a - input_b);
`else
        alu_lo = input_a - input_b;
`endif
      end
      OP_ACC: begin
        alu_carry = acc_sum[WIDTH];
        alu_lo    = acc_new;
      end
      default: begin
      end
    endcase
  end

  // Control state, accumulator and output register next values.
  // A multiply result loads as the state enters DONE.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (acc_clr) begin
      acc_d = '0;
    end
    case (state_q)
      IDLE:    if (mul_start) state_d = BUSY;
      BUSY:    if (mul_done)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept && (op_e != OP_MUL)) begin
      out_valid_d = 1'b1;
      result_d    = {{(RW-WIDTH-1){1'b0}}, alu_hi, alu_lo};
      carry_d     = alu_carry;
      zero_d      = ~alu_hi & (alu_lo == '0);
      if (op_e == OP_ACC) begin
        acc_d = acc_new;
      end
    end else if ((state_q == BUSY) && mul_done) begin
      out_valid_d = 1'b1;
      result_d    = mul_product;
      carry_d     = 1'b0;
      zero_d      = (mul_product == '0);
    end
  end

  // Registered state and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;

endmodule
